reorder_buffer: RTL and testbench

Circular reorder buffer for the out-of-order core. It allocates one entry per decoded instruction and returns that entry's index as the rename tag written into the register file. It captures results broadcast on the common data bus, answers operand lookups from dispatch, and retires entries in program order, driving the register file's commit port. On a mispredicted branch reaching the head it raises the global `clear` and the redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 24 ++
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 tb/tb_reorder_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
//   Shared constants for the reorder buffer: default geometry, architectural
//   register / PC widths, and the valid/busy encodings used by the entry state.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int TAG_W_DEF     = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int REG_W         = 5;
  localparam int PC_W          = 32;

  localparam logic [REG_W-1:0] NULL_REG = '0;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;
  localparam logic BUSY    = 1'b1;
  localparam logic FREE    = 1'b0;

  // Register x0 is the "no destination" encoding; such entries retire silently.
  function automatic logic writes_reg(input logic [REG_W-1:0] dest);
    return dest != NULL_REG;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular reorder buffer. Allocates one entry per decoded instruction and
//   hands back the entry index as the rename tag, captures CDB results,
//   answers operand lookups, and retires in program order. A mispredicted
//   branch at the head raises a one-cycle clear with the redirect PC.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state and outputs
//   ID_valid/_reg_dest/_is_branch   allocate request from decode
//   ID_tag, ROB_full    combinational tail index / full flag
//   CDB_*               result broadcast (tag, data, mispredict, target)
//   q1/q2_tag -> q1/q2_ready, q1/q2_data   combinational operand lookups
//   ROB_data_valid/_reg_dest/_tag/_data    registered commit port
//   clear, clear_pc     registered flush pulse and redirect PC
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ID_valid,
  input  logic [REG_W-1:0]  ID_reg_dest,
  input  logic              ID_is_branch,
  output logic [TAG_W-1:0]  ID_tag,
  output logic              ROB_full,
  input  logic              CDB_valid,
  input  logic [TAG_W-1:0]  CDB_tag,
  input  logic [DATA_W-1:0] CDB_data,
  input  logic              CDB_mispredict,
  input  logic [PC_W-1:0]   CDB_target,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              ROB_data_valid,
  output logic [REG_W-1:0]  ROB_reg_dest,
  output logic [TAG_W-1:0]  ROB_tag,
  output logic [DATA_W-1:0] ROB_data,
  output logic              clear,
  output logic [PC_W-1:0]   clear_pc
);

  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] ready;
  logic [ROB_DEPTH-1:0] is_branch;
  logic [ROB_DEPTH-1:0] mispredict;
  logic [REG_W-1:0]     dest   [ROB_DEPTH];
  logic [DATA_W-1:0]    value  [ROB_DEPTH];
  logic [PC_W-1:0]      target [ROB_DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic alloc_en;
  logic wb_en;
  logic commit_en;
  logic flush;

  assign ID_tag   = tail;
  assign ROB_full = (count == (TAG_W+1)'(ROB_DEPTH));

  // Decode/CDB inputs are ignored while the previous flush pulse is out.
  assign alloc_en  = ID_valid && !ROB_full && !clear;
  assign wb_en     = CDB_valid && (busy[CDB_tag] == BUSY) && !clear;
  assign commit_en = (busy[head] == BUSY) && ready[head];
  assign flush     = commit_en && is_branch[head] && mispredict[head];

  // Control: pointers, occupancy, busy bits and the registered commit port.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      ROB_data_valid <= INVALID;
      ROB_reg_dest   <= '0;
      ROB_tag        <= '0;
      ROB_data       <= '0;
      clear          <= 1'b0;
      clear_pc       <= '0;
    end else if (rdy) begin
      ROB_data_valid <= commit_en && writes_reg(dest[head]);
      if (commit_en) begin
        ROB_reg_dest <= dest[head];
        ROB_tag      <= head;
        ROB_data     <= value[head];
      end
      clear <= flush;
      if (flush) begin
        clear_pc <= target[head];
        busy     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (commit_en) begin
          busy[head] <= FREE;
          head       <= head + 1'b1;
        end
        if (alloc_en) begin
          busy[tail] <= BUSY;
          tail       <= tail + 1'b1;
        end
        case ({alloc_en, commit_en})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload: no reset needed, every use is qualified by busy.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      if (alloc_en) begin
        ready[tail]      <= 1'b0;
        dest[tail]       <= ID_reg_dest;
        is_branch[tail]  <= ID_is_branch;
        mispredict[tail] <= 1'b0;
      end
      if (wb_en) begin
        ready[CDB_tag]      <= 1'b1;
        value[CDB_tag]      <= CDB_data;
        mispredict[CDB_tag] <= CDB_mispredict;
        target[CDB_tag]     <= CDB_target;
      end
    end
  end

  // Operand lookups with same-cycle CDB bypass.
  always_comb begin
    q1_ready = (busy[q1_tag] == BUSY) && ready[q1_tag];
    q1_data  = q1_ready ? value[q1_tag] : '0;
    if (CDB_valid && (CDB_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_data  = CDB_data;
    end
    q2_ready = (busy[q2_tag] == BUSY) && ready[q2_tag];
    q2_data  = q2_ready ? value[q2_tag] : '0;
    if (CDB_valid && (CDB_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_data  = CDB_data;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Directed-vector bench for reorder_buffer: fill/full, single commit,
//   in-order retire of out-of-order results, lookup bypass, mispredict flush,
//   pointer wrap and rdy freeze.
module tb_reorder_buffer;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              ID_valid;
  logic [4:0]        ID_reg_dest;
  logic              ID_is_branch;
  logic [TAG_W-1:0]  ID_tag;
  logic              ROB_full;
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;
  logic              CDB_mispredict;
  logic [31:0]       CDB_target;
  logic [TAG_W-1:0]  q1_tag, q2_tag;
  logic              q1_ready, q2_ready;
  logic [DATA_W-1:0] q1_data, q2_data;
  logic              ROB_data_valid;
  logic [4:0]        ROB_reg_dest;
  logic [TAG_W-1:0]  ROB_tag;
  logic [DATA_W-1:0] ROB_data;
  logic              clear;
  logic [31:0]       clear_pc;

  int n_cmp = 0;
  int n_err = 0;

  reorder_buffer #(.ROB_DEPTH(16), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ID_valid(ID_valid), .ID_reg_dest(ID_reg_dest), .ID_is_branch(ID_is_branch),
    .ID_tag(ID_tag), .ROB_full(ROB_full),
    .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
    .CDB_mispredict(CDB_mispredict), .CDB_target(CDB_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data),
    .ROB_data_valid(ROB_data_valid), .ROB_reg_dest(ROB_reg_dest),
    .ROB_tag(ROB_tag), .ROB_data(ROB_data),
    .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] d,
                            input logic [TAG_W-1:0] t, input logic [31:0] v);
    chk({tag, ".valid"}, ROB_data_valid, 1);
    chk({tag, ".dest"},  ROB_reg_dest, d);
    chk({tag, ".tag"},   ROB_tag, t);
    chk({tag, ".data"},  ROB_data, v);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    ID_valid = 0; ID_reg_dest = 0; ID_is_branch = 0;
    CDB_valid = 0; CDB_tag = 0; CDB_data = 0; CDB_mispredict = 0; CDB_target = 0;
    q1_tag = 0; q2_tag = 0;
    tick(); tick();

    // Reset state
    chk("rst.id_tag", ID_tag, 0);
    chk("rst.full", ROB_full, 0);
    chk("rst.valid", ROB_data_valid, 0);
    chk("rst.data", ROB_data, 0);
    chk("rst.clear", clear, 0);
    chk("rst.clear_pc", clear_pc, 0);
    rst = 1'b0;

    // Fill all 16 entries
    for (int i = 0; i < 16; i++) begin
      ID_valid = 1; ID_reg_dest = 5'(i + 1);
      #1;
      chk($sformatf("fill.tag%0d", i), ID_tag, i);
      chk($sformatf("fill.notfull%0d", i), ROB_full, 0);
      tick();
    end
    chk("fill.full", ROB_full, 1);
    tick();  // 17th request must be ignored
    ID_valid = 0;
    chk("fill.tail_hold", ID_tag, 0);
    chk("fill.still_full", ROB_full, 1);

    // Entry 0 becomes ready, then reset lands on the edge it would commit
    CDB_valid = 1; CDB_tag = 0; CDB_data = 32'h77;
    tick();
    CDB_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("midrst.valid", ROB_data_valid, 0);
    chk("midrst.full", ROB_full, 0);
    chk("midrst.tag", ID_tag, 0);
    tick();
    chk("midrst.nocommit", ROB_data_valid, 0);

    // Single allocate/writeback/commit
    ID_valid = 1; ID_reg_dest = 5;
    tick();
    ID_valid = 0;
    CDB_valid = 1; CDB_tag = 0; CDB_data = 32'h1234;
    tick();
    CDB_valid = 0;
    chk("one.not_yet", ROB_data_valid, 0);
    tick();
    chk_commit("one", 5, 0, 32'h1234);
    tick();
    chk("one.pulse", ROB_data_valid, 0);

    // Out-of-order results, in-order retire (tags 1,2,3)
    for (int i = 1; i <= 3; i++) begin
      ID_valid = 1; ID_reg_dest = 5'(i);
      #1;
      chk($sformatf("ooo.tag%0d", i), ID_tag, i);
      tick();
    end
    ID_valid = 0;
    CDB_valid = 1; CDB_tag = 3; CDB_data = 32'hAB;
    q1_tag = 3; q2_tag = 1;
    #1;
    chk("byp.q1_ready", q1_ready, 1);
    chk("byp.q1_data", q1_data, 32'hAB);
    chk("byp.q2_ready", q2_ready, 0);
    chk("byp.q2_data", q2_data, 0);
    tick();
    CDB_tag = 2; CDB_data = 32'h20;
    tick();
    CDB_tag = 1; CDB_data = 32'h10;
    #1;
    chk("look.q1_ready", q1_ready, 1);
    chk("look.q1_data", q1_data, 32'hAB);
    tick();
    CDB_valid = 0;
    chk("ooo.wait", ROB_data_valid, 0);
    tick(); chk_commit("ooo1", 1, 1, 32'h10);
    tick(); chk_commit("ooo2", 2, 2, 32'h20);
    tick(); chk_commit("ooo3", 3, 3, 32'hAB);
    tick();
    chk("ooo.end", ROB_data_valid, 0);
    chk("look.free_ready", q1_ready, 0);
    chk("look.free_data", q1_data, 0);

    // Mispredicted branch (tag 4) with a completed younger entry (tag 5)
    ID_valid = 1; ID_reg_dest = 0; ID_is_branch = 1;
    #1; chk("br.tag", ID_tag, 4);
    tick();
    ID_reg_dest = 7; ID_is_branch = 0;
    tick();
    ID_valid = 0;
    CDB_valid = 1; CDB_tag = 5; CDB_data = 32'h55;
    tick();
    CDB_tag = 4; CDB_data = 0; CDB_mispredict = 1; CDB_target = 32'h100;
    tick();
    CDB_valid = 0; CDB_mispredict = 0;
    chk("br.no_clear_yet", clear, 0);
    tick();
    chk("br.clear", clear, 1);
    chk("br.clear_pc", clear_pc, 32'h100);
    chk("br.no_strobe", ROB_data_valid, 0);
    chk("br.id_tag0", ID_tag, 0);
    ID_valid = 1; ID_reg_dest = 9;  // ignored while clear is high
    tick();
    ID_valid = 0;
    chk("br.clear_pulse", clear, 0);
    chk("br.alloc_ignored", ID_tag, 0);
    chk("br.young_dropped", ROB_data_valid, 0);
    tick();
    chk("br.young_dropped2", ROB_data_valid, 0);
    chk("br.empty", ROB_full, 0);

    // Wrap: 40 allocations, each written 3 cycles later, committed one after
    for (int c = 0; c < 46; c++) begin
      ID_valid    = (c < 40);
      ID_reg_dest = 5'((c % 31) + 1);
      CDB_valid   = (c >= 3 && c < 43);
      CDB_tag     = 4'((c - 3) % 16);
      CDB_data    = 32'hA000 + 32'(c - 3);
      #1;
      if (c < 40) chk($sformatf("wrap.tag%0d", c), ID_tag, c % 16);
      chk($sformatf("wrap.notfull%0d", c), ROB_full, 0);
      tick();
      if (c >= 4 && c < 44) begin
        chk($sformatf("wrap.v%0d", c - 4), ROB_data_valid, 1);
        chk($sformatf("wrap.t%0d", c - 4), ROB_tag, (c - 4) % 16);
        chk($sformatf("wrap.d%0d", c - 4), ROB_data, 32'hA000 + 32'(c - 4));
      end else begin
        chk($sformatf("wrap.idle%0d", c), ROB_data_valid, 0);
      end
    end
    ID_valid = 0; CDB_valid = 0;

    // rdy freeze: commit strobe and pointers hold for 3 cycles
    ID_valid = 1; ID_reg_dest = 6;
    #1; chk("frz.tag", ID_tag, 8);
    tick();
    ID_valid = 0;
    CDB_valid = 1; CDB_tag = 8; CDB_data = 32'hBEEF;
    tick();
    CDB_valid = 0;
    tick();
    chk_commit("frz.pre", 6, 8, 32'hBEEF);
    rdy = 0; ID_valid = 1; ID_reg_dest = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz.valid%0d", i), ROB_data_valid, 1);
      chk($sformatf("frz.data%0d", i), ROB_data, 32'hBEEF);
      chk($sformatf("frz.idtag%0d", i), ID_tag, 9);
    end
    rdy = 1; ID_valid = 0;
    tick();
    chk("frz.released", ROB_data_valid, 0);
    chk("frz.idtag_end", ID_tag, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
